// File: rtl/bldc_pkg.sv
// Shared types and constants for the BLDC gate-drive path (dead-time guard).
package bldc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        H_ON = 2'd1,
        L_ON = 2'd2,
        DEAD = 2'd3
    } dtg_state_t;

    localparam int PH_A = 0;
    localparam int PH_B = 1;
    localparam int PH_C = 2;

    localparam int DEAD_CYCLES_DEFAULT = 50;

    // A request of 00 or 11, or a gated-off phase, resolves to both gates off.
    function automatic dtg_state_t dtg_target(input logic h, input logic l, input logic allow);
        if (!allow || (h == l)) return IDLE;
        return h ? H_ON : L_ON;
    endfunction

endpackage

// File: rtl/dtg_phase.sv
// Single-phase dead-time FSM; optional DTG_MIN_PULSE_EN adds a minimum on-time.
module dtg_phase
    import bldc_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
    parameter int CNT_W = 8
`ifdef DTG_MIN_PULSE_EN
    ,
    parameter int MIN_ON_CYCLES = 20
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic req_h,
    input  logic req_l,
    input  logic allow,
    output logic gate_h,
    output logic gate_l,
    output logic dead_active
);

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

    dtg_state_t state_q, state_d, target;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic gate_h_q, gate_l_q, dead_q;
    logic leave_ok;

`ifdef DTG_MIN_PULSE_EN
    localparam logic [CNT_W-1:0] ON_LOAD = CNT_W'(MIN_ON_CYCLES - 1);
    logic [CNT_W-1:0] ton_q, ton_d;

    // Forced shutdowns skip the minimum; ordinary target changes wait for it.
    always_comb begin
        leave_ok = (ton_q == '0) || !allow || (req_h && req_l);
        ton_d = (ton_q != '0) ? ton_q - 1'b1 : '0;
        if ((state_d == H_ON || state_d == L_ON) && state_d != state_q) ton_d = ON_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) ton_q <= '0;
        else     ton_q <= ton_d;
    end
`else
    assign leave_ok = 1'b1;
`endif

    always_comb begin
        target  = dtg_target(req_h, req_l, allow);
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = target;
            H_ON, L_ON: begin
                if (target != state_q && leave_ok) begin
                    state_d = DEAD;
                    cnt_d   = DEAD_LOAD;
                end
            end
            DEAD: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = target;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gate_h_q <= 1'b0;
            gate_l_q <= 1'b0;
            dead_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gate_h_q <= (state_d == H_ON);
            gate_l_q <= (state_d == L_ON);
            dead_q   <= (state_d == DEAD);
        end
    end

    assign gate_h      = gate_h_q;
    assign gate_l      = gate_l_q;
    assign dead_active = dead_q;

endmodule

// File: rtl/deadtime_gate_guard.sv
// Three-phase dead-time insertion with sticky shoot-through fault.
// Optional DTG_MIN_PULSE_EN enforces MIN_ON_CYCLES minimum conduction per phase.
module deadtime_gate_guard
    import bldc_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
    parameter int CNT_W = 8
`ifdef DTG_MIN_PULSE_EN
    ,
    parameter int MIN_ON_CYCLES = 20
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] pwm_h_in,
    input  logic [2:0] pwm_l_in,
    input  logic       fault_clr,
    output logic [2:0] gate_h,
    output logic [2:0] gate_l,
    output logic [2:0] dead_active,
    output logic       fault
);

    logic [2:0] illegal;
    logic       allow;
    logic       fault_q, fault_d;

    // A new illegal request outranks a simultaneous clear.
    always_comb begin
        illegal = pwm_h_in & pwm_l_in;
        allow   = enable & ~fault_q;
        fault_d = fault_q;
        if (illegal[PH_A] | illegal[PH_B] | illegal[PH_C]) fault_d = 1'b1;
        else if (fault_clr)                                  fault_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end

    assign fault = fault_q;

    for (genvar i = PH_A; i <= PH_C; i++) begin : g_phase
        dtg_phase #(
            .DEAD_CYCLES  (DEAD_CYCLES),
            .CNT_W        (CNT_W)
`ifdef DTG_MIN_PULSE_EN
            ,
            .MIN_ON_CYCLES(MIN_ON_CYCLES)
`endif
        ) u_phase (
            .clk        (clk),
            .rst        (rst),
            .req_h      (pwm_h_in[i]),
            .req_l      (pwm_l_in[i]),
            .allow      (allow),
            .gate_h     (gate_h[i]),
            .gate_l     (gate_l[i]),
            .dead_active(dead_active[i])
        );
    end

endmodule

// File: tb/tb_deadtime_gate_guard.sv
// Bench for deadtime_gate_guard: directed vector table plus randomized run against a timestamp model.
module tb_deadtime_gate_guard;

    localparam int DEAD   = 50;
    localparam int MIN_ON = 20;

    logic       clk = 1'b0;
    logic       rst, enable, fault_clr;
    logic [2:0] pwm_h_in, pwm_l_in;
    logic [2:0] gate_h, gate_l, dead_active;
    logic       fault;

    int vectors = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    deadtime_gate_guard dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pwm_h_in   (pwm_h_in),
        .pwm_l_in   (pwm_l_in),
        .fault_clr  (fault_clr),
        .gate_h     (gate_h),
        .gate_l     (gate_l),
        .dead_active(dead_active),
        .fault      (fault)
    );

    typedef struct {
        logic       rst, en, clr;
        logic [2:0] h, l;
        int         reps;
        logic [2:0] eh, el, ed;
        logic       ef;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic en, input logic clr,
                                input logic [2:0] h, input logic [2:0] l, input int reps,
                                input logic [2:0] eh, input logic [2:0] el,
                                input logic [2:0] ed, input logic ef);
        vec_t v;
        v.rst = r; v.en = en; v.clr = clr; v.h = h; v.l = l; v.reps = reps;
        v.eh = eh; v.el = el; v.ed = ed; v.ef = ef;
        tbl.push_back(v);
    endfunction

    // Model: which side conducts, and the edge numbers at which it last went off / on.
    int side[3];
    int off_edge[3];
    int on_edge[3];
    bit m_fault;
    int edge_n = 0;

    function automatic void modelStep(input logic r, input logic en, input logic clr,
                                      input logic [2:0] h, input logic [2:0] l);
        bit allow, forced, leave;
        int want;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                side[i] = 0; off_edge[i] = -100000; on_edge[i] = -100000;
            end
            m_fault = 1'b0;
            return;
        end
        allow = en && !m_fault;
        for (int i = 0; i < 3; i++) begin
            forced = !allow || (h[i] && l[i]);
            want = forced ? 0 : (h[i] ? 1 : (l[i] ? 2 : 0));
            if (side[i] != 0) begin
                leave = (want != side[i]);
`ifdef DTG_MIN_PULSE_EN
                leave = leave && (forced || (edge_n - on_edge[i] >= MIN_ON));
`endif
                if (leave) begin
                    side[i] = 0;
                    off_edge[i] = edge_n;
                end
            end else if (want != 0 && edge_n - off_edge[i] >= DEAD) begin
                side[i] = want;
                on_edge[i] = edge_n;
            end
        end
        if ((h & l) != 3'b000) m_fault = 1'b1;
        else if (clr)          m_fault = 1'b0;
    endfunction

    logic [2:0] m_h, m_l, m_d;

    function automatic void modelOutputs();
        for (int i = 0; i < 3; i++) begin
            m_h[i] = (side[i] == 1);
            m_l[i] = (side[i] == 2);
            m_d[i] = (side[i] == 0) && (edge_n - off_edge[i] < DEAD);
        end
    endfunction

    task automatic applyStimulus(input logic r, input logic en, input logic clr,
                                 input logic [2:0] h, input logic [2:0] l);
        rst = r; enable = en; fault_clr = clr; pwm_h_in = h; pwm_l_in = l;
        @(posedge clk);
        edge_n++;
        modelStep(r, en, clr, h, l);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] eh, input logic [2:0] el,
                               input logic [2:0] ed, input logic ef);
        vectors++;
        if (gate_h !== eh || gate_l !== el || dead_active !== ed || fault !== ef ||
            (gate_h & gate_l) != 3'b000) begin
            miscompares++;
            $display("[TB] FAIL %s @edge %0d: got h=%b l=%b dead=%b fault=%b, expected h=%b l=%b dead=%b fault=%b",
                     name, edge_n, gate_h, gate_l, dead_active, fault, eh, el, ed, ef);
        end
    endtask

    initial begin
        logic [1:0] req[3];
        logic [2:0] h, l;
        logic en, clr, r;

        rst = 1'b1; enable = 1'b1; fault_clr = 1'b0; pwm_h_in = '0; pwm_l_in = '0;

`ifndef DTG_MIN_PULSE_EN
        add(1, 1, 0, 3'b001, 3'b000, 3,  3'b000, 3'b000, 3'b000, 0);
        add(0, 1, 0, 3'b001, 3'b000, 4,  3'b001, 3'b000, 3'b000, 0);
        add(0, 1, 0, 3'b000, 3'b001, 50, 3'b000, 3'b000, 3'b001, 0);
        add(0, 1, 0, 3'b000, 3'b001, 2,  3'b000, 3'b001, 3'b000, 0);
        add(0, 1, 0, 3'b000, 3'b000, 10, 3'b000, 3'b000, 3'b001, 0);
        add(0, 1, 0, 3'b001, 3'b000, 40, 3'b000, 3'b000, 3'b001, 0);
        add(0, 1, 0, 3'b001, 3'b000, 2,  3'b001, 3'b000, 3'b000, 0);
        add(0, 1, 0, 3'b011, 3'b010, 1,  3'b001, 3'b000, 3'b000, 1);
        add(0, 1, 0, 3'b001, 3'b000, 50, 3'b000, 3'b000, 3'b001, 1);
        add(0, 1, 0, 3'b001, 3'b000, 5,  3'b000, 3'b000, 3'b000, 1);
        add(0, 1, 1, 3'b001, 3'b000, 1,  3'b000, 3'b000, 3'b000, 0);
        add(0, 1, 0, 3'b001, 3'b000, 2,  3'b001, 3'b000, 3'b000, 0);
        add(0, 1, 1, 3'b101, 3'b100, 1,  3'b001, 3'b000, 3'b000, 1);
        add(0, 1, 0, 3'b001, 3'b000, 50, 3'b000, 3'b000, 3'b001, 1);
        add(0, 1, 0, 3'b001, 3'b000, 2,  3'b000, 3'b000, 3'b000, 1);
        add(0, 1, 1, 3'b000, 3'b000, 1,  3'b000, 3'b000, 3'b000, 0);
        add(0, 1, 0, 3'b000, 3'b100, 3,  3'b000, 3'b100, 3'b000, 0);
        add(0, 0, 0, 3'b000, 3'b100, 20, 3'b000, 3'b000, 3'b100, 0);
        add(0, 1, 0, 3'b100, 3'b000, 30, 3'b000, 3'b000, 3'b100, 0);
        add(0, 1, 0, 3'b100, 3'b000, 2,  3'b100, 3'b000, 3'b000, 0);
`else
        add(1, 1, 0, 3'b000, 3'b000, 3,  3'b000, 3'b000, 3'b000, 0);
        add(0, 1, 0, 3'b001, 3'b000, 5,  3'b001, 3'b000, 3'b000, 0);
        add(0, 1, 0, 3'b000, 3'b000, 15, 3'b001, 3'b000, 3'b000, 0);
        add(0, 1, 0, 3'b000, 3'b000, 50, 3'b000, 3'b000, 3'b001, 0);
        add(0, 1, 0, 3'b000, 3'b000, 2,  3'b000, 3'b000, 3'b000, 0);
        add(0, 1, 0, 3'b001, 3'b000, 5,  3'b001, 3'b000, 3'b000, 0);
        add(0, 0, 0, 3'b001, 3'b000, 50, 3'b000, 3'b000, 3'b001, 0);
        add(0, 0, 0, 3'b001, 3'b000, 1,  3'b000, 3'b000, 3'b000, 0);
`endif

        $display("[TB] directed table: %0d entries", tbl.size());
        foreach (tbl[k]) begin
            for (int n = 0; n < tbl[k].reps; n++) begin
                applyStimulus(tbl[k].rst, tbl[k].en, tbl[k].clr, tbl[k].h, tbl[k].l);
                checkOutput($sformatf("table%0d.%0d", k, n), tbl[k].eh, tbl[k].el, tbl[k].ed, tbl[k].ef);
            end
        end

        $display("[TB] randomized run against reference model");
        for (int i = 0; i < 3; i++) req[i] = 2'd0;
        en = 1'b1;
        applyStimulus(1, 1, 0, 3'b000, 3'b000);
        applyStimulus(1, 1, 0, 3'b000, 3'b000);
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 39) == 0) req[i] = 2'($urandom_range(0, 2));
                h[i] = (req[i] == 2'd1);
                l[i] = (req[i] == 2'd2);
            end
            if ($urandom_range(0, 299) == 0) begin
                int p;
                p = $urandom_range(0, 2);
                h[p] = 1'b1;
                l[p] = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) en = ~en;
            clr = ($urandom_range(0, 59) == 0);
            r   = ($urandom_range(0, 1999) == 0);
            applyStimulus(r, en, clr, h, l);
            modelOutputs();
            checkOutput("random", m_h, m_l, m_d, m_fault);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
